// File: rtl/serial_addsub_ctrl_pkg.sv
// rtl/serial_addsub_ctrl_pkg.sv - shared FSM encodings and mode constants for adder/subtractor blocks
package serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_fa_cell.sv
// rtl/serial_addsub_ctrl_fa_cell.sv - single-bit full adder cell (combinational)
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority carry of the three input bits
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial add/sub controller; ADDSUB_OVF_EN enables signed overflow flag
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf
);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     opa;
    logic [W-1:0]     opb;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             run;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_cout;

    assign accept   = (state == ST_IDLE) && start;
    assign run      = (state == ST_RUN);
    assign last_bit = (cnt == CNT_W'(W - 1));

    fa_cell u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave RUN after the MSB is processed, DONE lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last_bit) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: latch operands on accept, then one bit per cycle LSB first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            opa    <= a;
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1
            opb    <= b ^ {W{sub == MODE_SUB}};
            carry  <= (sub == MODE_SUB);
            cnt    <= '0;
            result <= '0;
        end else if (run) begin
            carry  <= fa_cout;
            result <= {fa_sum, result[W-1:1]};
            opa    <= {1'b0, opa[W-1:1]};
            opb    <= {1'b0, opb[W-1:1]};
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                cout <= fa_cout;
            end
        end
    end

`ifdef ADDSUB_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (run && last_bit) begin
            ovf_q <= carry ^ fa_cout;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
